accum_lanes: RTL

- Multi-lane, multi-address successor to the single-pixel accumulator.
- Accumulates LANES signed pixels per beat into a DEPTH-entry partial-sum buffer indexed by `addr`, at a wide internal width with saturation.
- On the closing beat of a chain, emits a rounded, shifted, saturated DWIDTH result per lane, with per-lane overflow flags.
- Sits between the MAC array and the output/activation stage; ready/valid on both sides.

---
 rtl/accum_lanes.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/accum_lanes.sv
// Multi-lane, multi-address saturating accumulator with a DEPTH-entry partial-sum buffer.
// Closing beats emit a rounded, shifted, narrowed result per lane through one output register.
module accum_lanes #(
    parameter  int DWIDTH = 16,
    parameter  int AWIDTH = 24,
    parameter  int LANES  = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic [4:0]              qshift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    first,
    input  logic                    last,
    input  logic [AW-1:0]           addr,
    input  logic [LANES*DWIDTH-1:0] pixel_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW-1:0]           out_addr,
    output logic [LANES*DWIDTH-1:0] pixel_out,
    output logic [LANES-1:0]        ovf_out
);

    localparam logic signed [AWIDTH:0] DMAX = {{(AWIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH:0] DMIN = {{(AWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

    // Returns {saturated, sum} of base + sign-extended x, clamped to AWIDTH.
    function automatic logic [AWIDTH:0] acc_sat(input logic [AWIDTH-1:0] base,
                                                 input logic [DWIDTH-1:0] x);
        logic [AWIDTH:0] sum;
        sum = {base[AWIDTH-1], base} + {{(AWIDTH-DWIDTH+1){x[DWIDTH-1]}}, x};
        if (sum[AWIDTH] != sum[AWIDTH-1]) begin
            return {1'b1, sum[AWIDTH], {(AWIDTH-1){~sum[AWIDTH]}}};
        end else begin
            return {1'b0, sum[AWIDTH-1:0]};
        end
    endfunction

    // Returns {saturated, y}: round half up, arithmetic shift, narrow to DWIDTH.
    function automatic logic [DWIDTH:0] round_narrow(input logic [AWIDTH-1:0] s,
                                                     input logic [4:0] sh);
        logic signed [AWIDTH:0] one;
        logic signed [AWIDTH:0] rnd;
        logic signed [AWIDTH:0] r;
        one = {{AWIDTH{1'b0}}, 1'b1};
        rnd = (sh == 5'd0) ? {(AWIDTH+1){1'b0}} : (one <<< (sh - 5'd1));
        r   = $signed({s[AWIDTH-1], s}) + rnd;
        r   = r >>> sh;
        if (r > DMAX) begin
            return {1'b1, 1'b0, {(DWIDTH-1){1'b1}}};
        end else if (r < DMIN) begin
            return {1'b1, 1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            return {1'b0, r[DWIDTH-1:0]};
        end
    endfunction

    logic [AWIDTH-1:0]        buf_q     [DEPTH][LANES];
    logic [AWIDTH-1:0]        buf_d     [DEPTH][LANES];
    logic [LANES-1:0]         ovf_buf_q [DEPTH];
    logic [LANES-1:0]         ovf_buf_d [DEPTH];
    logic                     out_valid_q, out_valid_d;
    logic [AW-1:0]            out_addr_q, out_addr_d;
    logic [LANES*DWIDTH-1:0]  pixel_out_q, pixel_out_d;
    logic [LANES-1:0]         ovf_out_q, ovf_out_d;

    logic                     accept_s;
    logic [AWIDTH:0]          res_s [LANES];
    logic [DWIDTH:0]          nr_s  [LANES];
    logic [LANES-1:0]         sov_s;
    logic [LANES-1:0]         yov_s;
    logic [LANES*DWIDTH-1:0]  y_s;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign pixel_out = pixel_out_q;
    assign ovf_out   = ovf_out_q;

    // Per-lane accumulate and output formatting; buffer read is combinational so no bubble.
    always_comb begin
        sov_s = {LANES{1'b0}};
        yov_s = {LANES{1'b0}};
        y_s   = {(LANES*DWIDTH){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            res_s[i] = acc_sat(first ? {AWIDTH{1'b0}} : buf_q[addr][i],
                               pixel_in[i*DWIDTH +: DWIDTH]);
            sov_s[i] = (first ? 1'b0 : ovf_buf_q[addr][i]) | res_s[i][AWIDTH];
            nr_s[i]  = round_narrow(res_s[i][AWIDTH-1:0], qshift);
            y_s[i*DWIDTH +: DWIDTH] = nr_s[i][DWIDTH-1:0];
            yov_s[i] = sov_s[i] | nr_s[i][DWIDTH];
        end
    end

    // Partial-sum buffer update, written on every accepted beat including the closing one.
    always_comb begin
        buf_d     = buf_q;
        ovf_buf_d = ovf_buf_q;
        if (accept_s) begin
            for (int i = 0; i < LANES; i++) begin
                buf_d[addr][i] = res_s[i][AWIDTH-1:0];
            end
            ovf_buf_d[addr] = sov_s;
        end else begin
            buf_d     = buf_q;
            ovf_buf_d = ovf_buf_q;
        end
    end

    // Output register: a closing beat reloads it even while the previous result drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        pixel_out_d = pixel_out_q;
        ovf_out_d   = ovf_out_q;
        if (accept_s && last) begin
            out_valid_d = 1'b1;
            out_addr_d  = addr;
            pixel_out_d = y_s;
            ovf_out_d   = yov_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset clears every open chain and the output register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int i = 0; i < LANES; i++) begin
                    buf_q[e][i] <= {AWIDTH{1'b0}};
                end
                ovf_buf_q[e] <= {LANES{1'b0}};
            end
            out_valid_q <= 1'b0;
            out_addr_q  <= {AW{1'b0}};
            pixel_out_q <= {(LANES*DWIDTH){1'b0}};
            ovf_out_q   <= {LANES{1'b0}};
        end else begin
            buf_q       <= buf_d;
            ovf_buf_q   <= ovf_buf_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            pixel_out_q <= pixel_out_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

endmodule
